keypad_multitap_entry: RTL and testbench

//  Scans the 4x4 keypad, debounces it and turns phone-style multi-tap presses into ASCII letters.

---
 rtl/hangman_pkg.sv | 94 +++++++++
 rtl/keypad_scan_debounce.sv | 119 +++++++++++
 rtl/keypad_multitap_entry.sv | 115 +++++++++++
 tb/tb_keypad_multitap_entry.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared keypad types, key map and multi-tap letter group tables.
package hangman_pkg;

  typedef enum logic [3:0] {
    KEY_NONE,
    KEY_ABC,
    KEY_DEF,
    KEY_GHI,
    KEY_JKL,
    KEY_MNO,
    KEY_PQRS,
    KEY_TUV,
    KEY_WXYZ,
    KEY_SUBMIT,
    KEY_CLEAR
  } key_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_REL
  } deb_state_t;

  localparam logic [7:0] ASCII_NONE = 8'h00;

  // Cycles after a column change before the synchronised rows reflect that column.
  localparam int SYNC_SETTLE = 2;

  // One-hot pattern (bit3 = index 0) to index; only called on one-hot values.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic key_t key_decode(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    k = KEY_NONE;
    case ({row, col})
      4'b00_01: k = KEY_ABC;
      4'b00_10: k = KEY_DEF;
      4'b01_00: k = KEY_GHI;
      4'b01_01: k = KEY_JKL;
      4'b01_10: k = KEY_MNO;
      4'b10_00: k = KEY_PQRS;
      4'b10_01: k = KEY_TUV;
      4'b10_10: k = KEY_WXYZ;
      4'b11_00: k = KEY_SUBMIT;
      4'b11_10: k = KEY_CLEAR;
      default:  k = KEY_NONE;
    endcase
    return k;
  endfunction

  function automatic logic is_letter(input key_t k);
    return (k >= KEY_ABC) && (k <= KEY_WXYZ);
  endfunction

  function automatic logic [7:0] group_base(input key_t k);
    logic [7:0] b;
    b = ASCII_NONE;
    case (k)
      KEY_ABC:  b = 8'h41;
      KEY_DEF:  b = 8'h44;
      KEY_GHI:  b = 8'h47;
      KEY_JKL:  b = 8'h4A;
      KEY_MNO:  b = 8'h4D;
      KEY_PQRS: b = 8'h50;
      KEY_TUV:  b = 8'h54;
      KEY_WXYZ: b = 8'h57;
      default:  b = ASCII_NONE;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] group_size(input key_t k);
    logic [2:0] s;
    s = 3'd3;
    case (k)
      KEY_PQRS, KEY_WXYZ: s = 3'd4;
      default:            s = 3'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Row synchroniser, column scanner and press/release debouncer for a 4x4 keypad.
// Emits a one-cycle key_event with the decoded key on each debounced press.
module keypad_scan_debounce
  import hangman_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 5000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] input_row,
  output logic [3:0] scan_col,
  output logic       key_event,
  output key_t       key_code
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);

  logic [3:0] row_sync;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= input_row[gi];
          sync_reg <= meta_reg;
        end
      end
      assign row_sync[gi] = sync_reg;
    end
  endgenerate

  logic pressed;
  assign pressed = (row_sync != 4'b0000) && ((row_sync & (row_sync - 4'd1)) == 4'b0000);

  deb_state_t        state_reg, state_next;
  logic [3:0]        scan_col_reg, scan_col_next;
  logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic [3:0]        row_reg, row_next;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= ST_SCAN;
      scan_col_reg <= 4'b1000;
      scan_cnt_reg <= '0;
      deb_cnt_reg  <= '0;
      row_reg      <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      scan_col_reg <= scan_col_next;
      scan_cnt_reg <= scan_cnt_next;
      deb_cnt_reg  <= deb_cnt_next;
      row_reg      <= row_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    scan_col_next = scan_col_reg;
    scan_cnt_next = scan_cnt_reg;
    deb_cnt_next  = deb_cnt_reg;
    row_next      = row_reg;
    key_event     = 1'b0;
    case (state_reg)
      ST_SCAN: begin
        // Rows seen just after a column change still belong to the previous column.
        if (pressed && (scan_cnt_reg >= SCAN_W'(SYNC_SETTLE))) begin
          state_next   = ST_DEB_PRESS;
          row_next     = row_sync;
          deb_cnt_next = '0;
        end else if (scan_cnt_reg >= SCAN_W'(SCAN_DIV - 1)) begin
          scan_cnt_next = '0;
          scan_col_next = {scan_col_reg[0], scan_col_reg[3:1]};
        end else begin
          scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (row_sync != row_reg) begin
          state_next    = ST_SCAN;
          scan_cnt_next = '0;
        end else if (deb_cnt_reg >= DEB_W'(DEBOUNCE - 1)) begin
          state_next = ST_HELD;
          key_event  = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_next   = ST_DEB_REL;
          deb_cnt_next = '0;
        end
      end
      ST_DEB_REL: begin
        if (pressed) begin
          state_next = ST_HELD;
        end else if (deb_cnt_reg >= DEB_W'(DEBOUNCE - 1)) begin
          state_next    = ST_SCAN;
          scan_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end
      default: state_next = ST_SCAN;
    endcase
  end

  assign scan_col = scan_col_reg;
  assign key_code = key_decode(onehot_idx(row_reg), onehot_idx(scan_col_reg));

endmodule

// File: rtl/keypad_multitap_entry.sv
// Phone-style multi-tap letter entry on top of the debounced keypad scanner.
// Holds the pending letter, the tap timer and the letter/submit/clear pulses.
module keypad_multitap_entry
  import hangman_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int DEBOUNCE    = 5000,
  parameter int TAP_TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] input_row,
  output logic [3:0] scan_col,
  output logic [7:0] cur_letter,
  output logic       letter_valid,
  output logic [7:0] letter,
  output logic       submit_word,
  output logic       clear
);

  localparam int TAP_W = $clog2(TAP_TIMEOUT + 1);

  logic key_event;
  key_t key_code;

  keypad_scan_debounce #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .nRst      (nRst),
    .input_row (input_row),
    .scan_col  (scan_col),
    .key_event (key_event),
    .key_code  (key_code)
  );

  key_t             pending_key_reg, pending_key_next;
  logic [1:0]       tap_idx_reg, tap_idx_next;
  logic [TAP_W-1:0] tap_cnt_reg, tap_cnt_next;
  logic [7:0]       letter_reg, letter_next;
  logic             letter_valid_reg, letter_valid_next;
  logic             submit_word_reg, submit_word_next;
  logic             clear_reg, clear_next;
  logic [7:0]       pending_ascii;

  assign pending_ascii = (pending_key_reg == KEY_NONE) ? ASCII_NONE
                       : group_base(pending_key_reg) + {6'b000000, tap_idx_reg};

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pending_key_reg  <= KEY_NONE;
      tap_idx_reg      <= 2'd0;
      tap_cnt_reg      <= '0;
      letter_reg       <= ASCII_NONE;
      letter_valid_reg <= 1'b0;
      submit_word_reg  <= 1'b0;
      clear_reg        <= 1'b0;
    end else begin
      pending_key_reg  <= pending_key_next;
      tap_idx_reg      <= tap_idx_next;
      tap_cnt_reg      <= tap_cnt_next;
      letter_reg       <= letter_next;
      letter_valid_reg <= letter_valid_next;
      submit_word_reg  <= submit_word_next;
      clear_reg        <= clear_next;
    end
  end

  always_comb begin
    pending_key_next  = pending_key_reg;
    tap_idx_next      = tap_idx_reg;
    tap_cnt_next      = (tap_cnt_reg != '0) ? tap_cnt_reg - TAP_W'(1) : tap_cnt_reg;
    letter_next       = letter_reg;
    letter_valid_next = 1'b0;
    submit_word_next  = 1'b0;
    clear_next        = 1'b0;
    if (key_event) begin
      if (is_letter(key_code)) begin
        tap_cnt_next = TAP_W'(TAP_TIMEOUT);
        // Only a repeat of the same key inside the tap window advances within the group.
        if ((key_code == pending_key_reg) && (tap_cnt_reg != '0)) begin
          if (({1'b0, tap_idx_reg} + 3'd1) >= group_size(key_code)) begin
            tap_idx_next = 2'd0;
          end else begin
            tap_idx_next = tap_idx_reg + 2'd1;
          end
        end else begin
          pending_key_next = key_code;
          tap_idx_next     = 2'd0;
        end
      end else if (key_code == KEY_SUBMIT) begin
        if (pending_key_reg != KEY_NONE) begin
          letter_next       = pending_ascii;
          letter_valid_next = 1'b1;
          pending_key_next  = KEY_NONE;
          tap_idx_next      = 2'd0;
        end else begin
          submit_word_next = 1'b1;
        end
      end else if (key_code == KEY_CLEAR) begin
        pending_key_next = KEY_NONE;
        tap_idx_next     = 2'd0;
        clear_next       = 1'b1;
      end
    end
  end

  assign cur_letter   = pending_ascii;
  assign letter       = letter_reg;
  assign letter_valid = letter_valid_reg;
  assign submit_word  = submit_word_reg;
  assign clear        = clear_reg;

endmodule

// File: tb/tb_keypad_multitap_entry.sv
// Directed plus randomised multi-tap bench against a letter-level model of the keypad rules.
module tb_keypad_multitap_entry;

  logic       tb_clk = 1'b0;
  logic       nRst;
  logic [3:0] input_row;
  logic [3:0] scan_col;
  logic [7:0] cur_letter;
  logic       letter_valid;
  logic [7:0] letter;
  logic       submit_word;
  logic       clear;

  always #5 tb_clk = ~tb_clk;

  keypad_multitap_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE    (8),
    .TAP_TIMEOUT (64)
  ) dut (
    .clk          (tb_clk),
    .nRst         (nRst),
    .input_row    (input_row),
    .scan_col     (scan_col),
    .cur_letter   (cur_letter),
    .letter_valid (letter_valid),
    .letter       (letter),
    .submit_word  (submit_word),
    .clear        (clear)
  );

  // Physical keypad: a held key connects its row to its column's strobe.
  int         key_row = -1;
  int         key_col = -1;
  bit         glitch_on = 1'b0;
  logic [3:0] glitch_row = 4'b0000;

  always_comb begin
    input_row = 4'b0000;
    if (glitch_on) input_row = glitch_row;
    else if (key_row >= 0 && key_col >= 0 && scan_col[3-key_col]) input_row[3-key_row] = 1'b1;
  end

  int lv_cnt = 0, sw_cnt = 0, clr_cnt = 0, multi_cnt = 0;
  always @(negedge tb_clk) begin
    if (nRst === 1'b1) begin
      if (letter_valid) lv_cnt++;
      if (submit_word) sw_cnt++;
      if (clear) clr_cnt++;
      if (int'(letter_valid) + int'(submit_word) + int'(clear) > 1) multi_cnt++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Letter groups: keypad position, base ASCII and size.
  int g_row[8]  = '{0, 0, 1, 1, 1, 2, 2, 2};
  int g_col[8]  = '{1, 2, 0, 1, 2, 0, 1, 2};
  int g_base[8] = '{8'h41, 8'h44, 8'h47, 8'h4A, 8'h4D, 8'h50, 8'h54, 8'h57};
  int g_size[8] = '{3, 3, 3, 3, 3, 4, 3, 4};

  // Reference state of the multi-tap entry.
  int  pend_g = -1;
  int  pend_idx = 0;
  bit  tap_live = 1'b0;
  int  exp_lv = 0, exp_sw = 0, exp_clr = 0;
  logic [7:0] exp_letter = 8'h00;

  function automatic logic [7:0] model_cur();
    return (pend_g < 0) ? 8'h00 : 8'(g_base[pend_g] + pend_idx);
  endfunction

  task automatic press(input int r, input int c, input int extra_idle);
    @(negedge tb_clk);
    key_row = r;
    key_col = c;
    repeat (32) @(negedge tb_clk);
    key_row = -1;
    key_col = -1;
    repeat (12 + extra_idle) @(negedge tb_clk);
  endtask

  task automatic tap_letter(input int g, input int extra_idle);
    if (g == pend_g && tap_live) pend_idx = (pend_idx + 1) % g_size[g];
    else begin
      pend_g = g;
      pend_idx = 0;
    end
    tap_live = 1'b1;
    press(g_row[g], g_col[g], extra_idle);
    check($sformatf("tap_g%0d_cur", g), cur_letter, model_cur());
  endtask

  task automatic do_submit();
    if (pend_g >= 0) begin
      exp_letter = model_cur();
      exp_lv++;
      pend_g = -1;
      pend_idx = 0;
    end else exp_sw++;
    press(3, 0, 0);
    check("submit_cur", cur_letter, 8'h00);
    check("submit_letter", letter, exp_letter);
    check("submit_lv_cnt", lv_cnt, exp_lv);
    check("submit_sw_cnt", sw_cnt, exp_sw);
  endtask

  task automatic do_clear();
    pend_g = -1;
    pend_idx = 0;
    exp_clr++;
    press(3, 2, 0);
    check("clear_cur", cur_letter, 8'h00);
    check("clear_cnt", clr_cnt, exp_clr);
    check("clear_lv_cnt", lv_cnt, exp_lv);
  endtask

  task automatic idle_expire(input int cycles);
    repeat (cycles) @(negedge tb_clk);
    tap_live = 1'b0;
  endtask

  initial begin
    logic [3:0] s;
    int g, n;
    nRst = 1'b0;
    // 1: reset state and column rotation
    repeat (3) @(negedge tb_clk);
    check("rst_scan_col", scan_col, 4'b1000);
    check("rst_cur", cur_letter, 8'h00);
    check("rst_letter", letter, 8'h00);
    check("rst_pulses", {letter_valid, submit_word, clear}, 3'b000);
    nRst = 1'b1;
    @(negedge tb_clk);
    s = scan_col;
    check("scan_first", s, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge tb_clk);
      s = {s[0], s[3:1]};
      check($sformatf("scan_rot%0d", i), scan_col, s);
    end
    // 2: single letter then submit
    tap_letter(0, 0);
    do_submit();
    // 3: five taps on PQRS wrap back to P
    for (int i = 0; i < 5; i++) tap_letter(5, 0);
    do_submit();
    // 4: JKL twice, timeout, again
    tap_letter(3, 0);
    tap_letter(3, 0);
    idle_expire(100);
    tap_letter(3, 0);
    do_clear();
    // 5: short glitch on R1 produces nothing
    @(negedge tb_clk);
    glitch_row = 4'b0100;
    glitch_on = 1'b1;
    repeat (5) @(negedge tb_clk);
    glitch_on = 1'b0;
    repeat (30) @(negedge tb_clk);
    check("glitch_cur", cur_letter, 8'h00);
    check("glitch_pulses", lv_cnt + sw_cnt + clr_cnt, exp_lv + exp_sw + exp_clr);
    // 6: submit with nothing pending, clear with pending DEF
    do_submit();
    tap_letter(1, 0);
    do_clear();
    // randomised rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      g = $urandom_range(0, 7);
      n = $urandom_range(1, 6);
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 4) == 0) g = $urandom_range(0, 7);
        if ($urandom_range(0, 5) == 0) idle_expire($urandom_range(80, 120));
        tap_letter(g, $urandom_range(0, 4));
      end
      if ($urandom_range(0, 2) == 0) do_clear();
      else do_submit();
    end
    // 7: reset while a key is held, then re-debounce of the still-held key
    @(negedge tb_clk);
    key_row = 1;
    key_col = 1;
    repeat (32) @(negedge tb_clk);
    check("held_cur", cur_letter, 8'h4A);
    nRst = 1'b0;
    #1;
    check("midrst_cur", cur_letter, 8'h00);
    check("midrst_scan", scan_col, 4'b1000);
    repeat (3) @(negedge tb_clk);
    nRst = 1'b1;
    repeat (40) @(negedge tb_clk);
    check("rehold_cur", cur_letter, 8'h4A);
    check("rehold_pulses", lv_cnt + sw_cnt + clr_cnt, exp_lv + exp_sw + exp_clr);
    key_row = -1;
    key_col = -1;
    repeat (20) @(negedge tb_clk);
    check("rehold_release_cur", cur_letter, 8'h4A);
    check("exclusive_pulses", multi_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
